instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Holds the PC, drives the byte address to the instruction memory, captures the returned 32-bit little-endian word with its PC into a small FIFO, and hands {pc, instr} to decode with a valid/ready handshake. Supports branch redirect with flush, a fetch enable, and a retired-fetch counter.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset
QDEPTH, 2, fetch FIFO depth in entries (power of two, ≥2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
Inst_Address  output  64  byte address to instruction memory, equal to the PC register
Instruction  input  32  word returned by memory for Inst_Address, valid in the same cycle (combinational memory)
fetch_enable  input  1  1 = fetch allowed this cycle
branch_taken  input  1  redirect request, single-cycle pulse
branch_target  input  64  redirect byte address
out_valid  output  1  FIFO head valid
out_ready  input  1  decode accepts head
out_instr  output  32  instruction at FIFO head
out_pc  output  64  PC of FIFO head
fetch_count  output  32  number of entries popped since reset, wraps
fetch_fault  output  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- One clock; reset is synchronous and active-high; ports named clk and reset.
- Reset (sampled high at an edge): PC=RESET_PC, FIFO empty, out_valid=0, out_instr=0, out_pc=0, fetch_count=0, fetch_fault=0. Reset overrides every other input that cycle, including mid-stream with a full FIFO.
- Inst_Address = PC at all times (registered, no combinational path from inputs).
- push = fetch_enable & ~branch_taken & ~full & ~halted: FIFO writes {PC, Instruction}; PC <= PC+4 (64-bit wrap, FFFF_FFFF_FFFF_FFFC+4 -> 0).
- pop = out_valid & out_ready: head removed; fetch_count += 1.
- Simultaneous push and pop when full: push is blocked (full is evaluated on the pre-edge count); the pop still occurs; count drops by 1. When empty, no bypass: a pushed entry appears on out_valid one cycle after the push edge. Fetch-to-decode latency is 1 cycle.
- branch_taken=1: the pop handshake in that cycle is honoured (counted); then all FIFO entries are discarded (count=0, out_valid=0 next cycle); no push; PC <= aligned target. The first fetch from the target occurs in the next cycle; its entry is valid 2 cycles after the branch edge.
- fetch_enable=0: PC holds, no push; pops continue.
- out_instr/out_pc reflect the FIFO head; they are held stable while out_valid & ~out_ready. If empty, they hold their last value (0 after reset).
- FIFO: circular read/write pointers plus occupancy counter of clog2(QDEPTH)+1 bits; full = (count==QDEPTH).
- halted = fetch_fault (always 0 when the feature is disabled).

Optional Feature:
MISALIGN_TRAP_EN
- Defined: branch with branch_target[1:0]!=0 sets fetch_fault=1 (sticky until reset), flushes the FIFO, loads PC with the unaligned target unmodified, and stops all further pushes. Pops of remaining entries are impossible (FIFO flushed), so out_valid stays 0.
- Undefined: the target is loaded with bits [1:0] forced to 0; fetch_fault is tied to 0; fetch never halts.

Test Plan:
- Reset with RESET_PC=0, memory words 0:0F053483, 4:009A84B3, 8:00148493, C:0E953823, out_ready=1, fetch_enable=1 -> out_pc 0,4,8,C on consecutive cycles starting 1 cycle after reset release, with matching out_instr; fetch_count=4.
- out_ready=0 for 5 cycles -> FIFO holds 2 entries (pc 0,4), Inst_Address stalls at 8, head stable; raising out_ready drains in order with no loss or duplication.
- FIFO full with pop and fetch in the same cycle -> no push that cycle, count 2->1, PC unchanged; push resumes on the next cycle.
- branch_taken with target 0x100 while 2 entries are queued and a pop is active -> fetch_count+1, out_valid=0 the next cycle, Inst_Address=0x100, first out_pc=0x100 valid 2 cycles after the branch.
- Reset asserted mid-stream with a full FIFO and PC=0x40 -> next cycle out_valid=0, Inst_Address=RESET_PC, fetch_count=0.
- Branch target 0x102 -> with MISALIGN_TRAP_EN: fetch_fault=1, Inst_Address=0x102, no further out_valid; without: Inst_Address=0x100 and normal fetch.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Initiator side of the instruction-memory read interface. The PC register
//   drives Inst_Address directly. Memory answers combinationally on
//   Instruction. Each accepted fetch stores {pc, instr} in a small circular
//   FIFO, and decode drains that FIFO through a valid/ready handshake.
//   A branch redirect flushes the FIFO and reloads the PC.
//
//   Optional build macro: MISALIGN_TRAP_EN
//     defined   - a branch to a target with bits [1:0] != 0 raises a sticky
//                 fetch_fault. The PC loads the raw target, the FIFO is
//                 flushed, and fetching halts until reset.
//     undefined - the target is word-aligned by clearing bits [1:0], and
//                 fetch_fault is tied low.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   Inst_Address      : byte address to instruction memory (= PC)
//   Instruction       : word returned for Inst_Address in the same cycle
//   fetch_enable      : allow a fetch this cycle
//   branch_taken      : redirect pulse
//   branch_target     : redirect byte address
//   out_valid         : FIFO head valid
//   out_ready         : decode accepts the head
//   out_instr, out_pc : FIFO head contents (hold last value when empty)
//   fetch_count       : number of entries popped since reset (wraps)
//   fetch_fault       : sticky misaligned-target flag
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        fetch_enable,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;

  logic [63:0]   pc_q, pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] remaining;
  logic [31:0]   out_instr_q, out_instr_d;
  logic [63:0]   out_pc_q, out_pc_d;
  logic [31:0]   fetch_count_q, fetch_count_d;
  logic [95:0]   mem_q [QDEPTH];
  logic [95:0]   head_next;
  logic          full, halted, push, pop;

`ifdef MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign halted      = fault_q;
  assign fetch_fault = fault_q;
`else
  assign halted      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign full = (count_q == CW'(QDEPTH));
  assign push = fetch_enable & ~branch_taken & ~full & ~halted;
  assign pop  = (count_q != '0) & out_ready;

  always_comb begin
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fetch_count_d = fetch_count_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    head_next     = '0;
`ifdef MISALIGN_TRAP_EN
    fault_d       = fault_q;
`endif

    if (pop) begin
      rd_ptr_d      = rd_ptr_q + 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      pc_d     = pc_q + 64'd4;
    end
    count_d   = count_q + CW'(push) - CW'(pop);
    remaining = count_q - CW'(pop);

    if (branch_taken) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
`ifdef MISALIGN_TRAP_EN
      pc_d    = branch_target;
      fault_d = fault_q | (branch_target[1:0] != 2'b00);
`else
      pc_d    = branch_target & ~64'd3;
`endif
    end

    // Output registers preload the head that will be visible after this edge.
    // When every old entry drains in this cycle, that head is the word being
    // pushed. Otherwise the head is an existing slot, which a push never
    // overwrites.
    if (count_d != '0) begin
      head_next   = (remaining == '0) ? {pc_q, Instruction} : mem_q[rd_ptr_d];
      out_pc_d    = head_next[95:32];
      out_instr_d = head_next[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pc_q, Instruction};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      fetch_count_q <= '0;
`ifdef MISALIGN_TRAP_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      fetch_count_q <= fetch_count_d;
`ifdef MISALIGN_TRAP_EN
      fault_q       <= fault_d;
`endif
    end
  end

  assign Inst_Address = pc_q;
  assign out_valid    = (count_q != '0);
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign fetch_count  = fetch_count_q;

endmodule
